// File: rtl/counter_pkg.sv
// Shared types for the scalable loop counter: FSM state encoding and count-direction constants.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic CNT_UP   = 1'b0;
    localparam logic CNT_DOWN = 1'b1;

endpackage

// File: rtl/scalable_loop_counter_if.sv
// Control/status bundle of the loop counter; master drives requests, slave is the counter.
interface scalable_loop_counter_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned PASS_W = 4
);
    logic              i_start;
    logic              i_en;
    logic              i_clear;
    logic [WIDTH-1:0]  i_num_cnt;
    logic              i_mode;
    logic              i_repeat;
    logic [WIDTH-1:0]  o_cnt;
    logic              o_busy;
    logic              o_last;
    logic              o_done;
    logic [PASS_W-1:0] o_pass;

    modport master (
        output i_start, i_en, i_clear, i_num_cnt, i_mode, i_repeat,
        input  o_cnt, o_busy, o_last, o_done, o_pass
    );

    modport slave (
        input  i_start, i_en, i_clear, i_num_cnt, i_mode, i_repeat,
        output o_cnt, o_busy, o_last, o_done, o_pass
    );
endinterface

// File: rtl/loop_cnt_datapath.sv
// Count register with +1/-1 stepping, first/final value selection and the last-beat comparator.
module loop_cnt_datapath
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] load_num,
    input  logic             load_mode,
    input  logic [WIDTH-1:0] num,
    input  logic             mode,
    input  logic             run,
    output logic [WIDTH-1:0] cnt,
    output logic             last
);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] first_val, final_val, step_val;

    // load_num/load_mode come straight from the inputs on start, from the latched copy on reload
    assign first_val = (load_mode == CNT_DOWN) ? load_num - WIDTH'(1) : '0;
    assign final_val = (mode == CNT_DOWN) ? '0 : num - WIDTH'(1);
    assign step_val  = (mode == CNT_DOWN) ? cnt_q - WIDTH'(1) : cnt_q + WIDTH'(1);

    always_comb begin
        cnt_d = cnt_q;
        if (clear)     cnt_d = '0;
        else if (load) cnt_d = first_val;
        else if (step) cnt_d = step_val;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign cnt  = cnt_q;
    assign last = run && (cnt_q == final_val);
endmodule

// File: rtl/scalable_loop_counter.sv
// Start/busy/done loop counter: FSM, latched pass configuration and saturating pass count.
module scalable_loop_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned PASS_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    scalable_loop_counter_if.slave  bus
);
    state_e            state_q, state_d;
    logic [WIDTH-1:0]  num_q, num_d;
    logic              mode_q, mode_d;
    logic              rep_q, rep_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              dp_clear, dp_load, dp_step, dp_last, ld_mode;
    logic [WIDTH-1:0]  ld_num, cnt;

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        mode_d   = mode_q;
        rep_d    = rep_q;
        pass_d   = pass_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dp_clear = 1'b0;
        dp_load  = 1'b0;
        dp_step  = 1'b0;
        ld_num   = num_q;
        ld_mode  = mode_q;
        if (bus.i_clear) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            dp_clear = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.i_start) begin
                        num_d  = bus.i_num_cnt;
                        mode_d = bus.i_mode;
                        rep_d  = bus.i_repeat;
                        pass_d = '0;
                        busy_d = 1'b1;
                        if (bus.i_num_cnt == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                            dp_load = 1'b1;
                            ld_num  = bus.i_num_cnt;
                            ld_mode = bus.i_mode;
                        end
                    end
                end
                RUN: begin
                    if (bus.i_en) begin
                        if (dp_last) begin
                            if (pass_q != '1) pass_d = pass_q + PASS_W'(1);
                            done_d = 1'b1;
                            if (rep_q) begin
                                dp_load = 1'b1;
                            end else begin
                                state_d  = DONE;
                                dp_clear = 1'b1;
                            end
                        end else begin
                            dp_step = 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    dp_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            num_q   <= '0;
            mode_q  <= CNT_UP;
            rep_q   <= 1'b0;
            pass_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            mode_q  <= mode_d;
            rep_q   <= rep_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    loop_cnt_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .clear     (dp_clear),
        .load      (dp_load),
        .step      (dp_step),
        .load_num  (ld_num),
        .load_mode (ld_mode),
        .num       (num_q),
        .mode      (mode_q),
        .run       (state_q == RUN),
        .cnt       (cnt),
        .last      (dp_last)
    );

    assign bus.o_cnt  = cnt;
    assign bus.o_busy = busy_q;
    assign bus.o_last = dp_last;
    assign bus.o_done = done_q;
    assign bus.o_pass = pass_q;
endmodule

// File: tb/tb_scalable_loop_counter.sv
// Directed bench for scalable_loop_counter (WIDTH=8, PASS_W=2) with immediate-assertion checks.
module tb_scalable_loop_counter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    scalable_loop_counter_if #(.WIDTH(8), .PASS_W(2)) bus ();

    scalable_loop_counter #(
        .WIDTH  (8),
        .PASS_W (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int cnt, input int busy, input int last,
                           input int done, input int pass);
        chk({tag, " cnt"},  32'(bus.o_cnt),  32'(cnt));
        chk({tag, " busy"}, 32'(bus.o_busy), 32'(busy));
        chk({tag, " last"}, 32'(bus.o_last), 32'(last));
        chk({tag, " done"}, 32'(bus.o_done), 32'(done));
        chk({tag, " pass"}, 32'(bus.o_pass), 32'(pass));
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int n, input logic mode, input logic rep);
        bus.i_start   = 1'b1;
        bus.i_num_cnt = 8'(n);
        bus.i_mode    = mode;
        bus.i_repeat  = rep;
        step();
        bus.i_start   = 1'b0;
    endtask

    initial begin
        bus.i_start   = 1'b0;
        bus.i_en      = 1'b0;
        bus.i_clear   = 1'b0;
        bus.i_num_cnt = '0;
        bus.i_mode    = 1'b0;
        bus.i_repeat  = 1'b0;
        #12;
        chk_all("reset", 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();

        // Up count N=5, en held high
        bus.i_en = 1'b1;
        start(5, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk_all($sformatf("up5 beat%0d", k), k, 1, (k == 4) ? 1 : 0, 0, 0);
            step();
        end
        chk_all("up5 done", 0, 1, 0, 1, 1);
        step();
        chk_all("up5 idle", 0, 0, 0, 0, 1);

        // Down count N=4 with enable gaps
        start(4, 1'b1, 1'b0);
        chk_all("dn4 first", 3, 1, 0, 0, 0);
        begin
            logic [5:0] en_seq;
            int         exp_cnt [6];
            en_seq  = 6'b110110;   // applied LSB first: 0,1,1,0,1,1
            exp_cnt = '{3, 2, 1, 1, 0, 0};
            for (int k = 0; k < 5; k++) begin
                bus.i_en = en_seq[k];
                step();
                chk_all($sformatf("dn4 step%0d", k), exp_cnt[k], 1,
                        (exp_cnt[k] == 0) ? 1 : 0, 0, 0);
            end
            bus.i_en = en_seq[5];
            step();
            chk_all("dn4 done", 0, 1, 0, 1, 1);
        end
        step();
        chk_all("dn4 idle", 0, 0, 0, 0, 1);

        // Repeat N=2, pass counter saturates at 3
        bus.i_en = 1'b1;
        start(2, 1'b0, 1'b1);
        chk_all("rep first", 0, 1, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            step();
            chk_all($sformatf("rep cyc%0d", i), i % 2, 1, i % 2, (i % 2 == 0) ? 1 : 0,
                    (i / 2 > 3) ? 3 : i / 2);
        end
        bus.i_clear = 1'b1;
        step();
        bus.i_clear = 1'b0;
        chk_all("rep cleared", 0, 0, 0, 0, 3);

        // N=0: straight to DONE, pass cleared by start
        start(0, 1'b0, 1'b0);
        chk_all("n0 done", 0, 1, 0, 1, 0);
        step();
        chk_all("n0 idle", 0, 0, 0, 0, 0);

        // N=1: single-beat pass
        start(1, 1'b0, 1'b0);
        chk_all("n1 run", 0, 1, 1, 0, 0);
        step();
        chk_all("n1 done", 0, 1, 0, 1, 1);
        step();

        // N=255 up: no overflow, last on 254
        start(255, 1'b0, 1'b0);
        for (int k = 0; k < 255; k++) begin
            chk($sformatf("n255 cnt%0d", k), 32'(bus.o_cnt), 32'(k));
            if (k == 254) chk("n255 last", 32'(bus.o_last), 32'd1);
            step();
        end
        chk_all("n255 done", 0, 1, 0, 1, 1);
        step();

        // Clear on final beat of N=3 wins over done
        start(3, 1'b0, 1'b0);
        step();
        step();
        chk_all("clr pre", 2, 1, 1, 0, 0);
        bus.i_clear = 1'b1;
        step();
        chk_all("clr final", 0, 0, 0, 0, 0);
        // Start together with clear is ignored
        bus.i_start = 1'b1;
        bus.i_num_cnt = 8'd3;
        step();
        bus.i_start = 1'b0;
        bus.i_clear = 1'b0;
        chk_all("clr start", 0, 0, 0, 0, 0);

        // Start in RUN ignored; config changes after start have no effect
        start(3, 1'b0, 1'b0);
        bus.i_start   = 1'b1;
        bus.i_num_cnt = 8'd7;
        bus.i_mode    = 1'b1;
        step();
        chk_all("run start", 1, 1, 0, 0, 0);
        step();
        chk_all("run last", 2, 1, 1, 0, 0);
        bus.i_start = 1'b0;
        step();
        chk_all("run done", 0, 1, 0, 1, 1);
        // Start in DONE ignored
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        chk_all("done start", 0, 0, 0, 0, 1);

        // Async reset mid-pass
        bus.i_mode = 1'b0;
        start(8, 1'b0, 1'b0);
        step();
        step();
        step();
        chk("rst pre cnt", 32'(bus.o_cnt), 32'd3);
        #2 rst = 1'b0;
        #1;
        chk_all("rst async", 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        start(8, 1'b0, 1'b0);
        chk_all("rst restart", 0, 1, 0, 0, 0);
        step();
        chk("rst restart step", 32'(bus.o_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
